acess_ctrl: RTL and testbench

ACESS_CTRL -- requirements
Module: acess_ctrl

---
 rtl/acess_ctrl_pkg.sv | 31 +++
 rtl/acess_ctrl_senha_rom.sv | 26 ++
 rtl/acess_ctrl.sv | 163 ++++++++++++++++
 tb/tb_acess_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/acess_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// acess_ctrl_pkg
// Shared definitions for the password access controller:
//   - state_e        : controller FSM states (LOCKED exists only when the
//                      ACESS_CTRL_LOCKOUT_EN macro is defined)
//   - PW_W           : password width in bits
//   - N_ENTRIES_DEF  : default number of stored passwords
//   - ROM_INIT       : stored password table, address 0 first
// -----------------------------------------------------------------------------
package acess_ctrl_pkg;

    localparam int PW_W          = 8;
    localparam int N_ENTRIES_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_GRANT  = 3'd2,
        S_DENY   = 3'd3
`ifdef ACESS_CTRL_LOCKOUT_EN
        ,
        S_LOCKED = 3'd4
`endif
    } state_e;

    // Stored passwords; 0 is reserved as "no valid password".
    localparam logic [PW_W-1:0] ROM_INIT [N_ENTRIES_DEF] = '{
        8'd200, 8'd37, 8'd85, 8'd123, 8'd10, 8'd64, 8'd150, 8'd250
    };

endpackage

// File: rtl/acess_ctrl_senha_rom.sv
// -----------------------------------------------------------------------------
// senha_rom
// Combinational (asynchronous-read) password ROM.
// Ports:
//   addr_i : entry address
//   data_o : stored password at addr_i; 0 for addresses without an entry
// -----------------------------------------------------------------------------
module senha_rom
    import acess_ctrl_pkg::*;
#(
    parameter int N_ENTRIES = N_ENTRIES_DEF,
    parameter int AW        = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic [AW-1:0]   addr_i,
    output logic [PW_W-1:0] data_o
);

    // Address decode; entries beyond the stored table read as 0 (never a match).
    always_comb begin
        data_o = {PW_W{1'b0}};
        for (int i = 0; i < N_ENTRIES_DEF; i++) begin
            data_o = ((i < N_ENTRIES) && (addr_i == AW'(i))) ? ROM_INIT[i] : data_o;
        end
    end

endmodule

// File: rtl/acess_ctrl.sv
// -----------------------------------------------------------------------------
// acess_ctrl
// Password access controller. A rising edge of enter captures the typed
// password, which is then compared one ROM entry per cycle. A match raises
// resultado for HOLD_CYCLES cycles; exhausting the ROM denies access.
// Optional feature (macro ACESS_CTRL_LOCKOUT_EN): after MAX_FAILS consecutive
// denials the controller locks for LOCK_CYCLES cycles, ignoring enter.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   enter          : confirm key (level); its rising edge starts a check
//   senha_digitada : typed password
//   resultado      : registered grant output, 1 = access granted
// -----------------------------------------------------------------------------
module acess_ctrl
    import acess_ctrl_pkg::*;
#(
    parameter int N_ENTRIES   = N_ENTRIES_DEF,
    parameter int HOLD_CYCLES = 16,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enter,
    input  logic [PW_W-1:0] senha_digitada,
    output logic            resultado
);

    localparam int AW      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    // One counter serves both the grant hold and the lockout timer.
    localparam int CNT_MAX = (HOLD_CYCLES > LOCK_CYCLES) ?
                             ((HOLD_CYCLES > MAX_FAILS) ? HOLD_CYCLES : MAX_FAILS) :
                             ((LOCK_CYCLES > MAX_FAILS) ? LOCK_CYCLES : MAX_FAILS);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e          state_q, state_d;
    logic            enter_q;
    logic [PW_W-1:0] senha_q, senha_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            resultado_q, resultado_d;
    logic [PW_W-1:0] rom_data_s;
    logic            enter_rise_s;
    logic            match_s;
`ifdef ACESS_CTRL_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAILS + 1);
    logic [FW-1:0]   fail_q, fail_d;
`endif

    senha_rom #(
        .N_ENTRIES (N_ENTRIES),
        .AW        (AW)
    ) u_rom (
        .addr_i (addr_q),
        .data_o (rom_data_s)
    );

    assign enter_rise_s = enter & ~enter_q;
    // A zero ROM word marks an empty slot and must never grant.
    assign match_s      = (rom_data_s != {PW_W{1'b0}}) && (rom_data_s == senha_q);
    assign resultado    = resultado_q;

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        senha_d     = senha_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
`ifdef ACESS_CTRL_LOCKOUT_EN
        fail_d      = fail_q;
`endif
        // Output follows the state one cycle later, giving match-at-i -> k+i+2.
        resultado_d = (state_q == S_GRANT);

        case (state_q)
            S_IDLE: begin
                if (enter_rise_s) begin
                    senha_d = senha_digitada;
                    addr_d  = {AW{1'b0}};
                    state_d = S_SEARCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                if (match_s) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_GRANT;
`ifdef ACESS_CTRL_LOCKOUT_EN
                    fail_d  = {FW{1'b0}};
`endif
                end else if (addr_q == AW'(N_ENTRIES - 1)) begin
                    state_d = S_DENY;
                end else begin
                    addr_d  = addr_q + AW'(1);
                end
            end
            S_GRANT: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_DENY: begin
`ifdef ACESS_CTRL_LOCKOUT_EN
                if (fail_q == FW'(MAX_FAILS - 1)) begin
                    fail_d  = fail_q + FW'(1);
                    cnt_d   = {CW{1'b0}};
                    state_d = S_LOCKED;
                end else begin
                    fail_d  = fail_q + FW'(1);
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
`ifdef ACESS_CTRL_LOCKOUT_EN
            S_LOCKED: begin
                if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
                    cnt_d   = {CW{1'b0}};
                    fail_d  = {FW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            enter_q     <= 1'b0;
            senha_q     <= {PW_W{1'b0}};
            addr_q      <= {AW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            resultado_q <= 1'b0;
`ifdef ACESS_CTRL_LOCKOUT_EN
            fail_q      <= {FW{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            enter_q     <= enter;
            senha_q     <= senha_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            resultado_q <= resultado_d;
`ifdef ACESS_CTRL_LOCKOUT_EN
            fail_q      <= fail_d;
`endif
        end
    end

endmodule

// File: tb/tb_acess_ctrl.sv
// -----------------------------------------------------------------------------
// tb_acess_ctrl
// Directed scenarios followed by randomized traffic. Each clock edge the
// expected resultado is derived from a timeline model: a detected enter edge
// accepted at edge k either schedules a grant window [k+i+2, k+i+HOLD+1] or a
// denial, and records the first edge at which a new check can be accepted.
// -----------------------------------------------------------------------------
module tb_acess_ctrl;

    localparam int NE   = 8;
    localparam int HOLD = 16;
    localparam int MAXF = 3;
    localparam int LOCK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter = 1'b0;
    logic [7:0] senha = 8'd0;
    logic       resultado;

    always #5 clk = ~clk;

    acess_ctrl #(
        .N_ENTRIES   (NE),
        .HOLD_CYCLES (HOLD),
        .MAX_FAILS   (MAXF),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enter          (enter),
        .senha_digitada (senha),
        .resultado      (resultado)
    );

    int    rom_m [NE] = '{200, 37, 85, 123, 10, 64, 150, 250};
    int    edge_n  = 0;
    int    avail   = 0;
    int    gstart  = -1;
    int    gend    = -2;
    int    fails   = 0;
    logic  prev    = 1'b0;
    logic  exp_res = 1'b0;
    string sc      = "init";
    int    chk_n   = 0;
    int    pass_n  = 0;

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        chk_n++;
        if (obs === exp_v) begin
            pass_n++;
        end else begin
            $display("FAIL %s edge=%0d: resultado=%0b expected %0b", tag, edge_n, obs, exp_v);
        end
    endtask

    function automatic int find_idx(input int v);
        for (int i = 0; i < NE; i++) begin
            if (rom_m[i] == v) return i;
        end
        return -1;
    endfunction

    // Advance the timeline model by one clock edge using the current inputs.
    task automatic model_edge();
        int  idx;
        logic rise;
        edge_n++;
        if (rst) begin
            prev   = 1'b0;
            avail  = edge_n + 1;
            gstart = -1;
            gend   = -2;
            fails  = 0;
        end else begin
            rise = enter && !prev;
            prev = enter;
            if (rise && edge_n >= avail) begin
                idx = find_idx(int'(senha));
                if (idx >= 0) begin
                    gstart = edge_n + idx + 2;
                    gend   = gstart + HOLD - 1;
                    avail  = edge_n + idx + HOLD + 2;
                    fails  = 0;
                end else begin
                    avail = edge_n + NE + 2;
`ifdef ACESS_CTRL_LOCKOUT_EN
                    fails++;
                    if (fails == MAXF) begin
                        avail = avail + LOCK;
                        fails = 0;
                    end
`endif
                end
            end
        end
        exp_res = (edge_n >= gstart) && (edge_n <= gend);
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] s);
        rst   = r;
        enter = e;
        senha = s;
        @(posedge clk);
        model_edge();
        #1;
        chk(sc, resultado, exp_res);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [7:0] s);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, s);
    endtask

    task automatic pulse(input logic [7:0] s);
        step(1'b0, 1'b1, s);
    endtask

    initial begin
        sc = "reset";
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'd0);

        sc = "grant_first";
        step(1'b0, 1'b1, 8'd200);
        step(1'b0, 1'b1, 8'd200);
        idle(20, 8'd200);

        sc = "deny_1";
        pulse(8'd1);
        idle(12, 8'd1);

        sc = "grant_last";
        pulse(8'd250);
        idle(28, 8'd250);

        sc = "deny_199";
        pulse(8'd199);
        idle(12, 8'd199);

        sc = "ignore_second";
        pulse(8'd200);
        idle(2, 8'd1);
        pulse(8'd1);
        idle(6, 8'd1);
        pulse(8'd37);
        idle(24, 8'd37);

        sc = "rst_in_grant";
        pulse(8'd200);
        idle(5, 8'd200);
        step(1'b1, 1'b0, 8'd200);
        pulse(8'd85);
        idle(24, 8'd85);

        sc = "lockout";
        pulse(8'd1);
        idle(11, 8'd1);
        pulse(8'd2);
        idle(11, 8'd2);
        pulse(8'd3);
        idle(11, 8'd3);
        pulse(8'd200);
        idle(70, 8'd200);
        pulse(8'd200);
        idle(22, 8'd200);

        sc = "random";
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       e;
            logic [7:0] s;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin
                s = 8'(rom_m[$urandom_range(0, NE - 1)]);
            end else begin
                s = 8'($urandom_range(0, 255));
            end
            step(r, e, s);
        end

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
